io_port_responder: RTL and testbench
====================================

// Module: io_port_responder
// PURPOSE
//  Memory-mapped I/O responder on the data side of the single-cycle CPU.
//  - Serves CPU read/write accesses to 4 port registers.
//  - Buffers bytes from an external input device in a small FIFO.
//  - Hands CPU-written bytes to an external output device over valid/ready.
//  - Reads are combinational, so the CPU completes each I/O access in one instruction cycle.
// PARAMETERS
//  WIDTH  8  data width of CPU bus and device ports (must be >= 8)
//  DEPTH  4  input FIFO entries (power of 2, >= 2)
// PORTS
//  clk        in   1      system clock, all state on rising edge
//  reset      in   1      synchronous, active-high reset
//  cpu_we     in   1      CPU write strobe, one access per cycle
//  cpu_re     in   1      CPU read strobe
//  cpu_addr   in   2      port select: 0 IN, 1 OUT, 2 STATUS, 3 GPIO
//  cpu_wdata  in   WIDTH  CPU write data
//  cpu_rdata  out  WIDTH  read data, combinational from cpu_addr and current state
//  in_data    in   WIDTH  input device data
//  in_valid   in   1      input device offers in_data
//  in_ready   out  1      FIFO can accept; equals !full (registered state only)
//  out_data   out  WIDTH  byte presented to output device
//  out_valid  out  1      out_data valid
//  out_ready  in   1      output device accepts
//  gpio_out   out  WIDTH  general-purpose output register
// BEHAVIOUR
//  Reset: FIFO empty, in_ready=1, out_valid=0, out_data=0, gpio_out=0, sticky bits=0.
//  Reset mid-operation discards FIFO contents and any pending output byte.
//  Input FIFO:
//   - Push when in_valid && in_ready.
//   - Pop when cpu_re && cpu_addr==0 && !empty.
//   - Simultaneous push and pop (non-full): both occur, count unchanged.
//   - When full, in_ready=0 even if a pop happens that cycle (no bypass).
//   - Pointers wrap modulo DEPTH; count is $clog2(DEPTH)+1 bits.
//  Read map (cpu_rdata):
//   - 0: FIFO head; reads 0 when empty, no pop, sets rx_underrun.
//   - 1: out_data.
//   - 2: STATUS = {count[2:0]@[7:5], tx_overflow@4, rx_underrun@3, out_valid@2, full@1, !empty@0}; upper bits 0.
//   - 3: gpio_out.
//   - cpu_rdata is valid whenever addressed; the side effect (pop) only when cpu_re=1.
//  Output channel (1-entry holding register):
//   - Write to addr 1 is accepted if !out_valid || out_ready. On accept: out_data<=wdata, out_valid<=1.
//   - Handshake (out_valid && out_ready) with no accepted write: out_valid<=0 next edge.
//   - Handshake and write in the same cycle: old byte delivered, new byte loaded, out_valid stays 1.
//   - Write rejected (out_valid && !out_ready): data dropped, tx_overflow<=1.
//   - out_data is held stable while out_valid && !out_ready.
//  Other writes:
//   - Addr 3: gpio_out<=wdata.
//   - Addr 2: write-1-to-clear for bits 3 and 4; other bits read-only.
//   - Addr 0: write ignored.
//  cpu_re and cpu_we both high: both side effects apply independently.
//  Sticky bit set and clear in the same cycle: set wins.
//  Latency: pushed byte is visible at addr 0 on the cycle after the push edge.
// STRUCTURE
//  - Shared package io_pkg: address constants ADDR_IN/ADDR_OUT/ADDR_STATUS/ADDR_GPIO and status bit indices.
//  - Sub-module io_fifo (WIDTH, DEPTH): push/pop/head/full/empty/count.
//  - Top level holds the output register, GPIO, sticky bits and the read mux.
// TESTING
//  1. Reset then idle: in_ready=1, out_valid=0, gpio_out=0, STATUS reads 0x00.
//  2. Push 0x11,0x22,0x33,0x44 -> in_ready=0, STATUS=0x83. Read addr0 x4 -> 0x11..0x44 in order.
//     Fifth read returns 0 and sets bit 3. Write 0x08 to addr 2 clears it.
//  3. Full FIFO, in_valid=1 with a pop in the same cycle: no push that cycle. Push next cycle; count returns to 4.
//  4. Write 0xA5 to addr1 with out_ready=0 -> out_valid=1, out_data=0xA5. Write 0x5A -> dropped, STATUS bit4=1, out_data still 0xA5.
//  5. out_valid=1 and out_ready=1 with a write of 0x77 in the same cycle -> next cycle out_valid=1, out_data=0x77. No further write -> out_valid=0.
//  6. Assert reset with 3 bytes queued and out_valid=1 -> next cycle FIFO empty, out_valid=0, stickies cleared.

Source files
------------

// File: rtl/io_pkg.sv
// Shared definitions for the CPU-facing I/O port responder: port addresses and
// the bit layout of the STATUS register.
package io_pkg;

  typedef enum logic [1:0] {
    ADDR_IN     = 2'd0,
    ADDR_OUT    = 2'd1,
    ADDR_STATUS = 2'd2,
    ADDR_GPIO   = 2'd3
  } io_addr_e;

  localparam int ST_NOT_EMPTY   = 0;
  localparam int ST_FULL        = 1;
  localparam int ST_OUT_VALID   = 2;
  localparam int ST_RX_UNDERRUN = 3;
  localparam int ST_TX_OVERFLOW = 4;
  localparam int ST_COUNT_LSB   = 5;

endpackage

// File: rtl/io_fifo.sv
// Small synchronous FIFO buffering input-device bytes until the CPU reads them.
// Push and pop are gated internally by full/empty; head is the oldest entry.
module io_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             push_ok, pop_ok;

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;
  assign head  = mem_q[rd_ptr_q];

  // NOTE: every signal assigned in always_comb gets a default first, so no
  // path through the block leaves it unassigned and no latch is inferred.
  always_comb begin
    push_ok  = push && !full;
    pop_ok   = pop && !empty;
    wr_ptr_d = push_ok ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d = pop_ok  ? rd_ptr_q + PW'(1) : rd_ptr_q;
    count_d  = count_q;
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // NOTE: state flops use non-blocking assignments so every flop samples the
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: storage is not reset; empty entries are never observed because the
  // read mux returns zero whenever count is zero.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/io_port_responder.sv
// Memory-mapped I/O responder: input FIFO, 1-entry output holding register,
// GPIO register and sticky error bits behind a combinational read mux.
module io_port_responder
  import io_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cpu_we,
  input  logic             cpu_re,
  input  logic [1:0]       cpu_addr,
  input  logic [WIDTH-1:0] cpu_wdata,
  output logic [WIDTH-1:0] cpu_rdata,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] gpio_out
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] fifo_head;
  logic             fifo_full, fifo_empty;
  logic [CW-1:0]    fifo_count;

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic [WIDTH-1:0] gpio_q, gpio_d;
  logic             tx_overflow_q, tx_overflow_d;
  logic             rx_underrun_q, rx_underrun_d;

  logic             rd_in, wr_out, wr_status, out_accept;
  logic [WIDTH-1:0] status;

  assign rd_in     = cpu_re && (cpu_addr == ADDR_IN);
  assign wr_out    = cpu_we && (cpu_addr == ADDR_OUT);
  assign wr_status = cpu_we && (cpu_addr == ADDR_STATUS);

  io_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (in_valid),
    .pop   (rd_in),
    .wdata (in_data),
    .head  (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign in_ready  = !fifo_full;
  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign gpio_out  = gpio_q;

  always_comb begin
    status                          = '0;
    status[ST_COUNT_LSB +: 3]       = 3'(fifo_count);
    status[ST_TX_OVERFLOW]          = tx_overflow_q;
    status[ST_RX_UNDERRUN]          = rx_underrun_q;
    status[ST_OUT_VALID]            = out_valid_q;
    status[ST_FULL]                 = fifo_full;
    status[ST_NOT_EMPTY]            = !fifo_empty;

    cpu_rdata = '0;
    case (cpu_addr)
      ADDR_IN:     cpu_rdata = fifo_empty ? '0 : fifo_head;
      ADDR_OUT:    cpu_rdata = out_data_q;
      ADDR_STATUS: cpu_rdata = status;
      ADDR_GPIO:   cpu_rdata = gpio_q;
      default:     cpu_rdata = '0;
    endcase
  end

  always_comb begin
    // A full holding register can still take a new byte when the old one is
    // being delivered in the same cycle.
    out_accept  = wr_out && (!out_valid_q || out_ready);
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    if (out_accept) begin
      out_valid_d = 1'b1;
      out_data_d  = cpu_wdata;
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end

    gpio_d = (cpu_we && (cpu_addr == ADDR_GPIO)) ? cpu_wdata : gpio_q;

    // Sticky bits: a set in the same cycle as a write-1-to-clear wins.
    tx_overflow_d = (tx_overflow_q && !(wr_status && cpu_wdata[ST_TX_OVERFLOW]))
                    || (wr_out && !out_accept);
    rx_underrun_d = (rx_underrun_q && !(wr_status && cpu_wdata[ST_RX_UNDERRUN]))
                    || (rd_in && fifo_empty);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_q   <= 1'b0;
      out_data_q    <= '0;
      gpio_q        <= '0;
      tx_overflow_q <= 1'b0;
      rx_underrun_q <= 1'b0;
    end else begin
      out_valid_q   <= out_valid_d;
      out_data_q    <= out_data_d;
      gpio_q        <= gpio_d;
      tx_overflow_q <= tx_overflow_d;
      rx_underrun_q <= rx_underrun_d;
    end
  end

endmodule

// File: tb/tb_io_port_responder.sv
// Self-checking bench for io_port_responder: directed scenarios followed by
// random traffic, all checked against a queue-based reference model.
module tb_io_port_responder;
  import io_pkg::*;

  localparam int WIDTH = 8;
  localparam int DEPTH = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic             cpu_we, cpu_re;
  logic [1:0]       cpu_addr;
  logic [WIDTH-1:0] cpu_wdata, cpu_rdata;
  logic [WIDTH-1:0] in_data;
  logic             in_valid, in_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_valid, out_ready;
  logic [WIDTH-1:0] gpio_out;

  io_port_responder #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .cpu_we    (cpu_we),
    .cpu_re    (cpu_re),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_rdata (cpu_rdata),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .gpio_out  (gpio_out)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_bad    = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: FIFO as a queue, output channel and registers as plain variables.
  logic [7:0] m_q[$];
  logic       m_ov;
  logic [7:0] m_od, m_gpio;
  logic       m_txo, m_rxu;

  logic [7:0] last_rdata;
  logic       last_in_ready, last_out_valid;
  logic [7:0] last_out_data;

  function automatic logic [7:0] m_status();
    return {3'(m_q.size()), m_txo, m_rxu, m_ov, (m_q.size() == DEPTH), (m_q.size() != 0)};
  endfunction

  function automatic logic [7:0] m_rdata(input logic [1:0] a);
    case (a)
      2'd0:    return (m_q.size() != 0) ? m_q[0] : 8'h00;
      2'd1:    return m_od;
      2'd2:    return m_status();
      default: return m_gpio;
    endcase
  endfunction

  task automatic m_reset();
    m_q.delete();
    m_ov = 1'b0; m_od = '0; m_gpio = '0; m_txo = 1'b0; m_rxu = 1'b0;
  endtask

  task automatic idle_inputs();
    cpu_we = 0; cpu_re = 0; cpu_addr = 0; cpu_wdata = 0;
    in_valid = 0; in_data = 0; out_ready = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    idle_inputs();
    @(posedge clk);
    m_reset();
    #1 reset = 1'b0;
  endtask

  task automatic do_cycle(input logic we, input logic re, input logic [1:0] addr,
                          input logic [7:0] wd, input logic iv, input logic [7:0] id,
                          input logic ordy);
    logic push, pop, under, wr_out, acc, clr;
    @(negedge clk);
    cpu_we = we; cpu_re = re; cpu_addr = addr; cpu_wdata = wd;
    in_valid = iv; in_data = id; out_ready = ordy;
    #1;
    check("rdata",     cpu_rdata, m_rdata(addr));
    check("in_ready",  in_ready,  m_q.size() != DEPTH);
    check("out_valid", out_valid, m_ov);
    check("out_data",  out_data,  m_od);
    check("gpio_out",  gpio_out,  m_gpio);
    last_rdata     = cpu_rdata;
    last_in_ready  = in_ready;
    last_out_valid = out_valid;
    last_out_data  = out_data;

    push   = iv && (m_q.size() != DEPTH);
    pop    = re && (addr == 2'd0) && (m_q.size() != 0);
    under  = re && (addr == 2'd0) && (m_q.size() == 0);
    wr_out = we && (addr == 2'd1);
    acc    = wr_out && (!m_ov || ordy);
    clr    = we && (addr == 2'd2);
    m_txo  = (wr_out && !acc) || (m_txo && !(clr && wd[4]));
    m_rxu  = under || (m_rxu && !(clr && wd[3]));
    if (acc) begin
      m_ov = 1'b1; m_od = wd;
    end else if (m_ov && ordy) begin
      m_ov = 1'b0;
    end
    if (we && addr == 2'd3) m_gpio = wd;
    if (pop) void'(m_q.pop_front());
    if (push) m_q.push_back(id);
    @(posedge clk);
  endtask

  task automatic rd(input logic [1:0] a);
    do_cycle(1'b0, 1'b1, a, 8'h00, 1'b0, 8'h00, 1'b0);
  endtask

  task automatic wr(input logic [1:0] a, input logic [7:0] d, input logic ordy);
    do_cycle(1'b1, 1'b0, a, d, 1'b0, 8'h00, ordy);
  endtask

  task automatic push_byte(input logic [7:0] d);
    do_cycle(1'b0, 1'b0, 2'd2, 8'h00, 1'b1, d, 1'b0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] exp_seq [4];
    exp_seq[0] = 8'h11; exp_seq[1] = 8'h22; exp_seq[2] = 8'h33; exp_seq[3] = 8'h44;
    reset = 1'b1;
    idle_inputs();
    m_reset();
    do_reset();

    // 1: reset state
    rd(2'd2);
    check("t1_status",    last_rdata,     8'h00);
    check("t1_in_ready",  last_in_ready,  1'b1);
    check("t1_out_valid", last_out_valid, 1'b0);
    rd(2'd3);
    check("t1_gpio",      last_rdata,     8'h00);

    // 2: fill, drain in order, underrun and its clear
    for (int i = 0; i < 4; i++) push_byte(exp_seq[i]);
    rd(2'd2);
    check("t2_status_full", last_rdata,    8'h83);
    check("t2_in_ready",    last_in_ready, 1'b0);
    for (int i = 0; i < 4; i++) begin
      rd(2'd0);
      check("t2_head", last_rdata, exp_seq[i]);
    end
    rd(2'd0);
    check("t2_underrun_data", last_rdata, 8'h00);
    rd(2'd2);
    check("t2_underrun_bit", last_rdata, 8'h08);
    wr(2'd2, 8'h08, 1'b0);
    rd(2'd2);
    check("t2_cleared", last_rdata, 8'h00);

    // 3: full FIFO with pop and offered byte in the same cycle: no push
    for (int i = 0; i < 4; i++) push_byte(exp_seq[i]);
    do_cycle(1'b0, 1'b1, 2'd0, 8'h00, 1'b1, 8'h55, 1'b0);
    check("t3_pop_head", last_rdata, 8'h11);
    rd(2'd2);
    check("t3_count3", last_rdata, 8'h61);
    push_byte(8'h55);
    rd(2'd2);
    check("t3_count4", last_rdata, 8'h83);
    for (int i = 0; i < 4; i++) rd(2'd0);
    check("t3_last", last_rdata, 8'h55);

    // 4: output register fill, rejected write
    wr(2'd1, 8'hA5, 1'b0);
    rd(2'd1);
    check("t4_out_data",  last_out_data,  8'hA5);
    check("t4_out_valid", last_out_valid, 1'b1);
    wr(2'd1, 8'h5A, 1'b0);
    rd(2'd2);
    check("t4_overflow", last_rdata, 8'h14);
    rd(2'd1);
    check("t4_held", last_rdata, 8'hA5);

    // 5: handshake plus write in the same cycle, then drain
    wr(2'd1, 8'h77, 1'b1);
    rd(2'd1);
    check("t5_reload_data",  last_rdata,     8'h77);
    check("t5_reload_valid", last_out_valid, 1'b1);
    do_cycle(1'b0, 1'b0, 2'd1, 8'h00, 1'b0, 8'h00, 1'b1);
    rd(2'd2);
    check("t5_drained", last_out_valid, 1'b0);

    // 6: reset mid-operation
    for (int i = 0; i < 3; i++) push_byte(exp_seq[i]);
    wr(2'd1, 8'h99, 1'b0);
    rd(2'd0);
    do_reset();
    rd(2'd2);
    check("t6_status",    last_rdata,     8'h00);
    check("t6_out_valid", last_out_valid, 1'b0);
    check("t6_in_ready",  last_in_ready,  1'b1);

    // Random traffic
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(299) == 0) begin
        do_reset();
      end else begin
        do_cycle($urandom_range(99) < 30, $urandom_range(99) < 40,
                 2'($urandom_range(3)), 8'($urandom),
                 $urandom_range(99) < 50, 8'($urandom),
                 $urandom_range(99) < 50);
      end
    end

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
